// File: rtl/faultdetector_mul_pipe.sv
// Flow-controlled pipelined multiplier: operand register, exact product,
// round/shift/saturate, then delay slots; bubbles collapse under backpressure.
module faultdetector_mul_pipe #(
  parameter int A_W       = 14,
  parameter int B_W       = 15,
  parameter int P_W       = 29,
  parameter int NUM_STAGE = 4,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0,
  parameter int SHIFT     = 0,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   p,
  output logic             p_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int FW = A_W + B_W + 2;
  // First slot holding the final result: S3 when depth allows a product register in S2.
  localparam int FS = (NUM_STAGE >= 3) ? 3 : 2;
  localparam int XW = (FW + 1 > P_W + 2) ? FW + 1 : P_W + 2;
  localparam bit RS = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] RND  = (SHIFT > 0) ? (ONE <<< RSH) : {XW{1'b0}};
  localparam logic signed [XW-1:0] MAXV = RS ? (ONE <<< (P_W - 1)) - ONE : (ONE <<< P_W) - ONE;
  localparam logic signed [XW-1:0] MINV = RS ? -(ONE <<< (P_W - 1)) : {XW{1'b0}};

  logic [NUM_STAGE:1]              vld_q, vld_d, vld_src, adv;
  logic [A_W:0]                    a_q, a_d;
  logic [B_W:0]                    b_q, b_d;
  logic [NUM_STAGE:1][TAG_W-1:0]   tag_q;
  logic signed [FW-1:0]            a_sx, b_sx, prod_d, prod_q, sat_in;
  logic signed [XW-1:0]            ext_c, scl_c;
  logic [NUM_STAGE:FS][P_W-1:0]    p_q;
  logic [NUM_STAGE:FS]             ovf_q;
  logic [P_W-1:0]                  p_d;
  logic                            ovf_d;

  // A slot may load unless it and every slot downstream are full and the sink stalls.
  for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&vld_q[NUM_STAGE:k]);
  end

  assign in_ready = adv[1];
  assign vld_src  = {vld_q[NUM_STAGE-1:1], in_valid};
  assign vld_d    = (adv & vld_src) | (~adv & vld_q);

  always_comb begin
    a_d = (A_SIGNED != 0) ? {a[A_W-1], a} : {1'b0, a};
    b_d = (B_SIGNED != 0) ? {b[B_W-1], b} : {1'b0, b};
    a_sx = {{(FW-A_W-1){a_q[A_W]}}, a_q};
    b_sx = {{(FW-B_W-1){b_q[B_W]}}, b_q};
    prod_d = a_sx * b_sx;
  end

  assign sat_in = (FS == 3) ? prod_q : prod_d;

  // Round half up, arithmetic shift, then clamp to the result range.
  always_comb begin
    ext_c = {{(XW-FW){sat_in[FW-1]}}, sat_in};
    scl_c = (ext_c + RND) >>> SHIFT;
    p_d   = scl_c[P_W-1:0];
    ovf_d = 1'b0;
    if (scl_c > MAXV) begin
      p_d   = MAXV[P_W-1:0];
      ovf_d = 1'b1;
    end else if (scl_c < MINV) begin
      p_d   = MINV[P_W-1:0];
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      prod_q <= '0;
      p_q    <= '0;
      ovf_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (adv[1]) begin
        a_q      <= a_d;
        b_q      <= b_d;
        tag_q[1] <= in_tag;
      end
      if (adv[2]) prod_q <= prod_d;
      if (adv[FS]) begin
        p_q[FS]   <= p_d;
        ovf_q[FS] <= ovf_d;
      end
      for (int k = 2; k <= NUM_STAGE; k++)
        if (adv[k]) tag_q[k] <= tag_q[k-1];
      for (int k = FS + 1; k <= NUM_STAGE; k++)
        if (adv[k]) begin
          p_q[k]   <= p_q[k-1];
          ovf_q[k] <= ovf_q[k-1];
        end
    end
  end

  assign out_valid = vld_q[NUM_STAGE];
  assign p         = p_q[NUM_STAGE];
  assign p_ovf     = ovf_q[NUM_STAGE];
  assign out_tag   = tag_q[NUM_STAGE];

endmodule

// File: tb/tb_faultdetector_mul_pipe.sv
// Five multiplier configurations share one input stream; each keeps its own
// scoreboard of expected {tag, ovf, p} computed with plain integer arithmetic.
module tb_faultdetector_mul_pipe;

  localparam int ND = 5;
  localparam int AS [ND] = '{0, 1, 0, 1, 1};
  localparam int BS [ND] = '{0, 0, 0, 1, 0};
  localparam int PW [ND] = '{29, 29, 16, 8, 29};
  localparam int SH [ND] = '{0, 0, 0, 0, 4};
  localparam int NS [ND] = '{4, 2, 3, 5, 8};

  logic        clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
  logic [13:0] a = '0;
  logic [14:0] b = '0;
  logic [7:0]  in_tag = '0;
  logic [ND-1:0]        ir, ov, fv;
  logic [ND-1:0][28:0]  pv;
  logic [ND-1:0][7:0]   tv;
  logic [15:0] p2;
  logic [7:0]  p3;

  int n_chk = 0, n_bad = 0, cyc = 0;
  bit lat_on = 0, hold_v = 0, streaming = 0;
  logic [37:0] held, e;
  int acc_c;
  logic [37:0] expq [ND][$];
  int          accq [ND][$];

  logic [13:0] da [8] = '{14'd16383, 14'h2000, 14'h3FFF, 14'd300, 14'h3F9C, 14'd24, 14'd23, 14'h3FE8};
  logic [14:0] db [8] = '{15'd32767, 15'd3, 15'd32767, 15'd300, 15'd2, 15'd1, 15'd1, 15'd1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  faultdetector_mul_pipe #(.NUM_STAGE(4)) u_d0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready), .p(pv[0]), .p_ovf(fv[0]), .out_tag(tv[0]));
  faultdetector_mul_pipe #(.A_SIGNED(1), .NUM_STAGE(2)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready), .p(pv[1]), .p_ovf(fv[1]), .out_tag(tv[1]));
  faultdetector_mul_pipe #(.P_W(16), .NUM_STAGE(3)) u_d2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready), .p(p2), .p_ovf(fv[2]), .out_tag(tv[2]));
  faultdetector_mul_pipe #(.A_SIGNED(1), .B_SIGNED(1), .P_W(8), .NUM_STAGE(5)) u_d3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[3]), .out_ready(out_ready), .p(p3), .p_ovf(fv[3]), .out_tag(tv[3]));
  faultdetector_mul_pipe #(.A_SIGNED(1), .SHIFT(4), .NUM_STAGE(8)) u_d4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[4]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[4]), .out_ready(out_ready), .p(pv[4]), .p_ovf(fv[4]), .out_tag(tv[4]));

  assign pv[2] = {13'd0, p2};
  assign pv[3] = {21'd0, p3};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer product, round half up, floor shift, clamp.
  function automatic logic [37:0] model(input int k, input logic [13:0] ai, input logic [14:0] bi,
                                        input logic [7:0] t);
    longint x, y, pr, hi, lo;
    logic ovf;
    logic [63:0] r;
    x = (AS[k] != 0) ? longint'($signed(ai)) : longint'(ai);
    y = (BS[k] != 0) ? longint'($signed(bi)) : longint'(bi);
    pr = x * y;
    if (SH[k] > 0) pr = (pr + (longint'(1) <<< (SH[k] - 1))) >>> SH[k];
    if (AS[k] != 0 || BS[k] != 0) begin
      hi = (longint'(1) <<< (PW[k] - 1)) - 1;
      lo = -(longint'(1) <<< (PW[k] - 1));
    end else begin
      hi = (longint'(1) <<< PW[k]) - 1;
      lo = 0;
    end
    ovf = 1'b0;
    if (pr > hi) begin pr = hi; ovf = 1'b1; end
    else if (pr < lo) begin pr = lo; ovf = 1'b1; end
    r = 64'(pr) & ((64'd1 << PW[k]) - 64'd1);
    return {t, ovf, r[28:0]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (!reset_n) begin
        chk("rst_out_valid", ov[k], 0);
        chk("rst_in_ready", ir[k], 1);
        expq[k].delete();
        accq[k].delete();
      end else begin
        chk("in_ready", ir[k], !(expq[k].size() == NS[k] && !out_ready));
        if (ov[k] && out_ready) begin
          if (expq[k].size() == 0) chk("spurious_out", ov[k], 0);
          else begin
            e = expq[k].pop_front();
            acc_c = accq[k].pop_front();
            chk($sformatf("out%0d", k), {tv[k], fv[k], pv[k]}, e);
            if (lat_on) chk("latency", cyc - acc_c, NS[k]);
          end
        end
        if (in_valid && ir[k]) begin
          expq[k].push_back(model(k, a, b, in_tag));
          accq[k].push_back(cyc);
        end
      end
    end
    if (!reset_n) hold_v = 0;
    else begin
      if (hold_v) chk("stall_hold", {ov[0], tv[0], fv[0], pv[0]}, {1'b1, held});
      hold_v = ov[0] && !out_ready;
      held = {tv[0], fv[0], pv[0]};
    end
  end

  task automatic send(input logic [13:0] av, input logic [14:0] bv, input logic [7:0] t);
    bit acc;
    a = av; b = bv; in_tag = t; in_valid = 1; acc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = ir[0];
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int tot;
    in_valid = 0;
    tot = 1;
    for (int i = 0; i < 400 && tot != 0; i++) begin
      tot = 0;
      for (int k = 0; k < ND; k++) tot += expq[k].size();
      if (tot != 0) begin @(posedge clk); #1; end
    end
    chk("drain", tot, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_p", pv[k], 0);
      chk("rst_ovf", fv[k], 0);
      chk("rst_tag", tv[k], 0);
    end
    reset_n = 1;
    @(posedge clk); #1;

    // Directed test-plan vectors, no backpressure, latency checked
    lat_on = 1;
    for (int i = 0; i < 8; i++) send(da[i], db[i], 8'h5A + 8'(i));
    idle(2);
    for (int i = 0; i < 8; i++) begin send(da[i], db[i], 8'(i)); idle(3); end
    drain();
    lat_on = 0;

    // Back-to-back tags 0..19 with a random out_ready pattern and a 6-cycle stall
    streaming = 1;
    fork
      begin
        for (int i = 0; i < 20; i++) send(14'($urandom), 15'($urandom), 8'(i));
        in_valid = 0;
        streaming = 0;
      end
      begin
        for (int i = 0; i < 2000 && streaming; i++) begin
          out_ready = (i >= 4 && i < 10) ? 1'b0 : 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // Random traffic with gaps and corner operands
    streaming = 1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [13:0] ra;
          logic [14:0] rb;
          ra = 14'($urandom);
          rb = 15'($urandom);
          case ($urandom_range(0, 5))
            0: ra = 14'h3FFF;
            1: ra = 14'h2000;
            2: rb = 15'h7FFF;
            3: rb = 15'h4000;
            default: ;
          endcase
          send(ra, rb, 8'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 0;
        streaming = 0;
      end
      begin
        for (int i = 0; i < 5000 && streaming; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // Mid-stream reset with products in flight
    out_ready = 1;
    for (int i = 0; i < 3; i++) send(14'd100 + 14'(i), 15'd7, 8'hE0 + 8'(i));
    idle(1);
    reset_n = 0;
    #1;
    for (int k = 0; k < ND; k++) chk("rst_now", ov[k], 0);
    @(posedge clk); #1;
    reset_n = 1;
    idle(12);
    lat_on = 1;
    send(14'd1234, 15'd4321, 8'hC3);
    idle(1);
    drain();
    lat_on = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
